// File: rtl/ta_param_writer.sv
// Tile-accelerator parameter writer: packs polygon headers and strip vertices into VRAM
// and emits one triangle-strip object-list word per strip. Optional macro: TA_SHADOW_EN.

module ta_param_writer #(
    parameter int ADDR_W    = 24,
    parameter int MAX_VERTS = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] param_base,
    input  logic              ta_valid,
    input  logic [31:0]       ta_data,
    input  logic              ta_eos,
    input  logic              ta_shadow,
    output logic              ta_ready,
    output logic              vram_wr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [31:0]       vram_dout,
    input  logic              vram_wait,
    output logic              ol_valid,
    output logic [31:0]       ol_word,
    input  logic              ol_ready,
    output logic              overflow,
    output logic              busy
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] VERT = 3'd2;
    localparam logic [2:0] EMIT = 3'd3;
    localparam logic [2:0] DROP = 3'd4;
    localparam int VW = $clog2(MAX_VERTS + 1);

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] wptr_r, hdr_ptr_r, vram_addr_r;
    logic [31:0]       vram_dout_r, ol_word_r;
    logic              vram_wr_r, ol_valid_r, overflow_r, ovf_pend_r, rdy_en_r;
    logic              texture_r, offset_r, uv16_r, shadow_r;
    logic [2:0]        hdr_cnt_r, word_cnt_r;
    logic [VW-1:0]     vcnt_r;

    logic [2:0]        hdr_len_s, vert_words_s, skip_s;
    logic [VW-1:0]     vcnt_next_s;
    logic [20:0]       word_off_s;
    logic              ready_s, accept_s, write_state_s, shadow_in_s;

`ifdef TA_SHADOW_EN
    assign shadow_in_s = ta_shadow;
`else
    logic shadow_unused_s;
    assign shadow_unused_s = ta_shadow;
    assign shadow_in_s     = 1'b0;
`endif

    // Triangle t of the strip maps to mask bit (5 - t); a strip of n vertices has n - 2 triangles.
    function automatic logic [5:0] tri_mask(input logic [VW-1:0] n);
        logic [5:0] m;
        m = 6'd0;
        for (int t = 0; t < 6; t++) begin
            if (int'(n) > t + 2) m[5 - t] = 1'b1;
            else                 m[5 - t] = 1'b0;
        end
        return m;
    endfunction

    // Per-polygon geometry derived from the captured header flags.
    always_comb begin
        hdr_len_s = 3'd3;
        if (shadow_r) hdr_len_s = 3'd5;
        else          hdr_len_s = 3'd3;
        vert_words_s = 3'd4 + (texture_r ? (uv16_r ? 3'd1 : 3'd2) : 3'd0) + {2'b00, offset_r};
        skip_s       = vert_words_s - 3'd3;
        vcnt_next_s  = vcnt_r + VW'(1);
        word_off_s   = 21'((hdr_ptr_r - param_base) >> 2);
    end

    // Input handshake: a stalled VRAM write or a frame restart blocks new words.
    always_comb begin
        ready_s       = 1'b0;
        write_state_s = 1'b0;
        if (state_r == IDLE || state_r == HDR || state_r == VERT) write_state_s = 1'b1;
        else                                                       write_state_s = 1'b0;
        if (rdy_en_r && (write_state_s || state_r == DROP) && !(vram_wr_r && vram_wait) && !frame_start)
            ready_s = 1'b1;
        else
            ready_s = 1'b0;
        accept_s = ta_valid && ready_s;
    end

    // Strip sequencing, VRAM write port and object-list output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;       wptr_r      <= '0;
            hdr_ptr_r   <= '0;         vram_addr_r <= '0;
            vram_dout_r <= 32'd0;      ol_word_r   <= 32'd0;
            vram_wr_r   <= 1'b0;       ol_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;       ovf_pend_r  <= 1'b0;
            rdy_en_r    <= 1'b0;       texture_r   <= 1'b0;
            offset_r    <= 1'b0;       uv16_r      <= 1'b0;
            shadow_r    <= 1'b0;       hdr_cnt_r   <= 3'd0;
            word_cnt_r  <= 3'd0;       vcnt_r      <= '0;
        end else if (frame_start) begin
            state_r    <= IDLE;
            wptr_r     <= param_base;
            overflow_r <= 1'b0;
            ovf_pend_r <= 1'b0;
            vram_wr_r  <= 1'b0;
            ol_valid_r <= 1'b0;
            rdy_en_r   <= 1'b1;
        end else begin
            rdy_en_r <= 1'b1;
            if (!(vram_wr_r && vram_wait)) vram_wr_r <= accept_s && write_state_s;
            if (accept_s && write_state_s) begin
                vram_addr_r <= wptr_r;
                vram_dout_r <= ta_data;
                wptr_r      <= wptr_r + ADDR_W'(4);
            end
            case (state_r)
                IDLE: if (accept_s) begin
                    texture_r <= ta_data[25];
                    offset_r  <= ta_data[24];
                    uv16_r    <= ta_data[22];
                    shadow_r  <= shadow_in_s;
                    hdr_ptr_r <= wptr_r;
                    hdr_cnt_r <= 3'd1;
                    state_r   <= HDR;
                end
                HDR: if (accept_s) begin
                    if (hdr_cnt_r == hdr_len_s - 3'd1) begin
                        word_cnt_r <= 3'd0;
                        vcnt_r     <= '0;
                        state_r    <= VERT;
                    end else begin
                        hdr_cnt_r <= hdr_cnt_r + 3'd1;
                    end
                end
                VERT: if (accept_s) begin
                    if (word_cnt_r == vert_words_s - 3'd1) begin
                        word_cnt_r <= 3'd0;
                        vcnt_r     <= vcnt_next_s;
                        if (ta_eos) begin
                            state_r <= EMIT;
                        end else if (vcnt_next_s == VW'(MAX_VERTS)) begin
                            overflow_r <= 1'b1;
                            ovf_pend_r <= 1'b1;
                            state_r    <= EMIT;
                        end
                    end else begin
                        word_cnt_r <= word_cnt_r + 3'd1;
                    end
                end
                // The entry is offered only once the final vertex write has left the port.
                EMIT: if (ol_valid_r) begin
                    if (ol_ready) begin
                        ol_valid_r <= 1'b0;
                        ovf_pend_r <= 1'b0;
                        state_r    <= ovf_pend_r ? DROP : IDLE;
                    end
                end else if (!vram_wr_r || !vram_wait) begin
                    ol_valid_r <= 1'b1;
                    ol_word_r  <= {1'b0, tri_mask(vcnt_r), shadow_r, skip_s, word_off_s};
                end
                DROP: if (accept_s && ta_eos) state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign ta_ready  = ready_s;
    assign vram_wr   = vram_wr_r;
    assign vram_addr = vram_addr_r;
    assign vram_dout = vram_dout_r;
    assign ol_valid  = ol_valid_r;
    assign ol_word   = ol_word_r;
    assign overflow  = overflow_r;
    assign busy      = (state_r != IDLE) || vram_wr_r;

endmodule

// File: tb/tb_ta_param_writer.sv
// Self-checking bench for ta_param_writer: directed scenarios plus randomized strips
// checked against a word-list reference model of the parameter layout.

module tb_ta_param_writer;
    localparam int MAXV = 8;

    logic        clock = 1'b0, reset_n = 1'b0, frame_start = 1'b0;
    logic [23:0] param_base = 24'd0;
    logic        ta_valid = 1'b0, ta_eos = 1'b0, ta_shadow = 1'b0;
    logic [31:0] ta_data = 32'd0;
    logic        vram_wait = 1'b0, ol_ready = 1'b0;
    logic        ta_ready, vram_wr, ol_valid, overflow, busy;
    logic [23:0] vram_addr;
    logic [31:0] vram_dout, ol_word;

    ta_param_writer #(.ADDR_W(24), .MAX_VERTS(MAXV)) dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .param_base(param_base),
        .ta_valid(ta_valid), .ta_data(ta_data), .ta_eos(ta_eos), .ta_shadow(ta_shadow),
        .ta_ready(ta_ready), .vram_wr(vram_wr), .vram_addr(vram_addr), .vram_dout(vram_dout),
        .vram_wait(vram_wait), .ol_valid(ol_valid), .ol_word(ol_word), .ol_ready(ol_ready),
        .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    int          n_pass = 0, n_total = 0;
    logic [23:0] act_addr[$], exp_addr[$];
    logic [31:0] act_data[$], exp_data[$], act_ol[$], exp_ol[$];
    logic [23:0] m_ptr = 24'd0, m_base = 24'd0;
    bit          m_ovf = 1'b0;
    bit          wait_rand = 1'b0;
    int          ol_mode = 1;
    logic [31:0] last_ol, last_nwr, first_addr;

    // Observe every write the arbiter takes and every object-list handshake.
    always @(posedge clock) begin
        if (reset_n && vram_wr && !vram_wait) begin
            act_addr.push_back(vram_addr);
            act_data.push_back(vram_dout);
        end
        if (reset_n && ol_valid && ol_ready) act_ol.push_back(ol_word);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_bg();
        vram_wait = wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        ol_ready  = (ol_mode == 2) ? 1'($urandom_range(0, 1)) : (ol_mode == 1);
    endtask

    task automatic send(input logic [31:0] d, input bit eos);
        bit ok;
        ok = 1'b0;
        ta_valid = 1'b1; ta_data = d; ta_eos = eos;
        for (int i = 0; i < 200 && !ok; i++) begin
            drive_bg();
            #1 ok = ta_ready;
            @(posedge clock);
            @(negedge clock);
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic frame_pulse(input logic [23:0] base);
        @(negedge clock);
        vram_wait = 1'b0; param_base = base; frame_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0;
        m_ptr = base; m_base = base; m_ovf = 1'b0;
    endtask

    task automatic do_reset(input logic [23:0] base);
        @(negedge clock);
        reset_n = 1'b0; param_base = base; ta_valid = 1'b0; vram_wait = 1'b0; ol_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_ta_ready", 32'(ta_ready), 32'd0);
        check("rst_vram_wr", 32'(vram_wr), 32'd0);
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        check("rst_vram_dout", vram_dout, 32'd0);
        check("rst_ol_valid", 32'(ol_valid), 32'd0);
        check("rst_ol_word", ol_word, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        m_ptr = 24'd0; m_base = base; m_ovf = 1'b0;
    endtask

    task automatic do_hold();
        logic [23:0] a;
        logic [31:0] d;
        vram_wait = 1'b1;
        #1 a = vram_addr; d = vram_dout;
        check("hold_wr_pending", 32'(vram_wr), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            check("hold_wr", 32'(vram_wr), 32'd1);
            check("hold_addr", 32'(vram_addr), 32'(a));
            check("hold_dout", vram_dout, d);
            check("hold_ready", 32'(ta_ready), 32'd0);
        end
        vram_wait = 1'b0;
    endtask

    task automatic do_abort();
        vram_wait = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ta_valid = 1'b1; ta_data = $urandom; frame_start = 1'b1;
        #1 check("abort_ready", 32'(ta_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0; ta_valid = 1'b0;
        #1;
        check("abort_vram_wr", 32'(vram_wr), 32'd0);
        check("abort_ol_valid", 32'(ol_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        m_ptr = m_base; m_ovf = 1'b0;
    endtask

    task automatic do_ol_hold();
        bit seen;
        logic [31:0] w;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            drive_bg();
            #1 seen = ol_valid;
            if (!seen) begin
                @(posedge clock);
                @(negedge clock);
            end
        end
        check("ol_hold_seen", 32'(seen), 32'd1);
        w = ol_word;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            check("ol_hold_valid", 32'(ol_valid), 32'd1);
            check("ol_hold_word", ol_word, w);
            check("ol_hold_ready", 32'(ta_ready), 32'd0);
        end
        ol_mode = 1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            drive_bg();
            #1 done = !busy;
            if (!done) begin
                @(posedge clock);
                @(negedge clock);
            end
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare();
        check("n_writes", 32'(act_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            check("wr_addr", 32'(act_addr[i]), 32'(exp_addr[i]));
            check("wr_data", act_data[i], exp_data[i]);
        end
        check("n_ol", 32'(act_ol.size()), 32'(exp_ol.size()));
        for (int i = 0; i < act_ol.size() && i < exp_ol.size(); i++)
            check("ol_word", act_ol[i], exp_ol[i]);
        check("overflow", 32'(overflow), 32'(m_ovf));
        last_nwr   = 32'(act_addr.size());
        last_ol    = (act_ol.size() > 0) ? act_ol[act_ol.size() - 1] : 32'hDEAD_BEEF;
        first_addr = (act_addr.size() > 0) ? 32'(act_addr[0]) : 32'hDEAD_BEEF;
        act_addr.delete(); exp_addr.delete(); act_data.delete(); exp_data.delete();
        act_ol.delete(); exp_ol.delete();
    endtask

    // Model: enumerate the words of one polygon, decide which reach VRAM, and build the entry.
    task automatic run_strip(input logic [31:0] w0, input int nv, input bit shd,
                             input int hold_at, input int abort_at, input bit ol_hold);
        logic [31:0] wq[$];
        bit          eq[$], wrq[$];
        int          hl, vw, vc, nsend;
        bit          eff_sh;
        logic [23:0] hptr;
        logic [31:0] e;
`ifdef TA_SHADOW_EN
        eff_sh = shd;
`else
        eff_sh = 1'b0;
`endif
        hl = eff_sh ? 5 : 3;
        vw = 4 + (w0[25] ? (w0[22] ? 1 : 2) : 0) + int'(w0[24]);
        for (int k = 0; k < hl; k++) begin
            wq.push_back((k == 0) ? w0 : $urandom);
            eq.push_back($urandom_range(0, 3) == 0);
            wrq.push_back(1'b1);
        end
        for (int v = 0; v < nv; v++)
            for (int j = 0; j < vw; j++) begin
                wq.push_back($urandom);
                if (j == vw - 1) eq.push_back(v == nv - 1);
                else             eq.push_back(v < MAXV && $urandom_range(0, 3) == 0);
                wrq.push_back(v < MAXV);
            end
        nsend = (abort_at >= 0) ? abort_at : wq.size();
        hptr = m_ptr;
        for (int k = 0; k < nsend; k++)
            if (wrq[k]) begin
                exp_addr.push_back(m_ptr);
                exp_data.push_back(wq[k]);
                m_ptr = m_ptr + 24'd4;
            end
        if (abort_at < 0) begin
            vc = (nv > MAXV) ? MAXV : nv;
            if (nv > MAXV) m_ovf = 1'b1;
            e = 32'd0;
            for (int t = 0; t < 6; t++) if (t < vc - 2) e[30 - t] = 1'b1;
            e[24]    = eff_sh;
            e[23:21] = 3'(vw - 3);
            e[20:0]  = 21'((hptr - m_base) >> 2);
            exp_ol.push_back(e);
        end
        ta_shadow = shd;
        for (int k = 0; k < nsend; k++) begin
            if (k == hold_at) do_hold();
            send(wq[k], eq[k]);
        end
        ta_valid = 1'b0; ta_eos = 1'b0;
        if (abort_at >= 0) begin
            do_abort();
        end else begin
            if (ol_hold) begin
                ol_mode = 0;
                do_ol_hold();
            end
            wait_idle();
        end
        compare();
    endtask

    initial begin
        do_reset(24'd0);

        frame_pulse(24'h100000);
        run_strip(32'h0000_0000, 3, 1'b0, -1, -1, 1'b0);
        check("t1_ol", last_ol, 32'h4020_0000);
        check("t1_hdr_addr", first_addr, 32'h0010_0000);
        check("t1_nwr", last_nwr, 32'd15);
        run_strip(32'h0000_0000, 3, 1'b0, -1, -1, 1'b0);
        check("t1b_offset", 32'(last_ol[20:0]), 32'h0000_000F);

        run_strip(32'h0000_0000, 2, 1'b0, -1, -1, 1'b0);
        check("two_vert_mask", 32'(last_ol[30:25]), 32'd0);
        run_strip(32'h0000_0000, 1, 1'b0, -1, -1, 1'b0);

        run_strip(32'h0000_0000, 4, 1'b0, 8, -1, 1'b0);

        run_strip(32'h0000_0000, 5, 1'b0, -1, 9, 1'b0);
        run_strip(32'h0100_0000, 3, 1'b0, -1, -1, 1'b1);
        check("abort_restart_addr", first_addr, 32'h0010_0000);

        frame_pulse(24'h100000);
        run_strip(32'h0000_0000, 9, 1'b0, -1, -1, 1'b0);
        check("ovf_ol", last_ol, 32'h7E20_0000);
        check("ovf_nwr", last_nwr, 32'd35);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_idle", 32'(busy), 32'd0);

        do_reset(24'd0);
        run_strip(32'h0340_0000, 4, 1'b0, -1, -1, 1'b0);
        check("tex_ol", last_ol, 32'h6060_0000);
        check("tex_nwr", last_nwr, 32'd27);

        frame_pulse(24'hFFFFF8);
        run_strip(32'h0000_0000, 3, 1'b0, -1, -1, 1'b0);

        wait_rand = 1'b1;
        ol_mode   = 2;
        for (int s = 0; s < 14; s++) begin
            if ($urandom_range(0, 3) == 0) frame_pulse(24'($urandom) & 24'hFFFFFC);
            run_strip($urandom, int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)), -1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ta_param_writer.md
# ta_param_writer

Writes polygon parameter data from the tile-accelerator input stream into VRAM in the same layout the ISP consumes. Each polygon arrives as a header (ISP/TSP/TCW) followed by strip vertices. The block packs the data sequentially from a frame-relative write pointer. At the end of each strip it emits one triangle-strip object-list word (mask, shadow, skip, parameter offset) for the object-list builder. It sits between the TA input FIFO and the VRAM arbiter write port.

## Interface
Parameters:
- ADDR_W, 24, VRAM byte-address width.
- MAX_VERTS, 8, maximum vertices per strip (6 triangles).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse: write pointer <= param_base, clear overflow, abort any strip.
- param_base  in  24  parameter buffer byte base, 4-byte aligned.
- ta_valid  in  1  input word valid.
- ta_data  in  32  input word.
- ta_eos  in  1  end of strip; meaningful only on the last word of a vertex.
- ta_shadow  in  1  sampled with header word 0.
- ta_ready  out  1  word accepted when ta_valid && ta_ready.
- vram_wr  out  1  write request.
- vram_addr  out  24  write byte address.
- vram_dout  out  32  write data.
- vram_wait  in  1  arbiter stall; while high, the request is held.
- ol_valid  out  1  object-list word valid.
- ol_word  out  32  object-list word.
- ol_ready  in  1  consumer accept.
- overflow  out  1  sticky; a strip exceeded MAX_VERTS.
- busy  out  1  state != IDLE or vram_wr pending.

## Operation
- States: IDLE, HDR, VERT, EMIT, DROP.
- IDLE: the first accepted word is header word 0.
  - Capture texture = d[25], offset = d[24], uv16 = d[22].
  - Latch hdr_ptr = wptr; go HDR.
- HDR: accept the remaining header words, then go VERT.
  - Header is 3 words total; 5 words with the shadow feature (see Configuration).
- vert_words = 3 + (texture ? (uv16 ? 1 : 2) : 0) + 1 + offset; range 4..7.
  - skip = vert_words - 3.
- VERT: count words per vertex and count vertices (vcnt).
  - On the last word of a vertex: vcnt++.
  - If ta_eos is set on that word: go EMIT.
  - Else if vcnt reaches MAX_VERTS: set overflow, go EMIT, then DROP.
  - ta_eos on any other word (header or mid-vertex) is ignored.
- Every accepted word in HDR or VERT is written once.
  - vram_addr = wptr, then wptr += 4.
  - wptr wraps modulo 2^24.
- DROP: accept and discard words without writing. The word carrying ta_eos returns the block to IDLE.
- ol_word bit fields:
  - [31] = 0 (strip).
  - [30:25]: bit (30 - t) set for each triangle t < vcnt - 2; triangle 0 maps to bit 30.
  - [24] = shadow.
  - [23:21] = skip.
  - [20:0] = (hdr_ptr - param_base) >> 2, in words.
- vcnt < 3 at ta_eos: mask = 0; the entry is still emitted.
- After ol_valid && ol_ready: go IDLE, or DROP if an overflow is pending.
- frame_start, in any state:
  - Go IDLE, wptr <= param_base, overflow <= 0.
  - An in-flight vram_wr is dropped; ol_valid is deasserted.
  - frame_start has priority over a simultaneous accept.

## Timing
- Reset values:
  - ta_ready = 0, vram_wr = 0, vram_addr = 0, vram_dout = 0.
  - ol_valid = 0, ol_word = 0, overflow = 0, busy = 0.
  - Internal wptr = 0, state = IDLE.
- ta_ready = (state is IDLE, HDR, VERT or DROP) && !(vram_wr && vram_wait) && !frame_start.
  - ta_ready is low in EMIT.
- Write latency: an accepted word appears on vram_wr/addr/dout in the next cycle.
- While vram_wait is high, vram_wr, vram_addr and vram_dout hold stable and no new word is accepted.
- ol_valid rises in the first EMIT cycle with no vram_wr pending, i.e. after the last vertex write has been taken. This gives at least 1 cycle after the final accept.
- ol_valid and ol_word hold until ol_ready.
- Throughput: one word per clock when vram_wait is low.

## Configuration
- TA_SHADOW_EN defined:
  - ol_word[24] = ta_shadow sampled with header word 0.
  - When shadow = 1, the header is 5 words (ISP, TSP, TCW, TSP2, TCW2).
- TA_SHADOW_EN undefined:
  - ta_shadow is ignored, ol_word[24] = 0, and the header is always 3 words.

## Test plan
- Non-textured, no offset, 3 vertices, param_base = 0x100000:
  - Header written at 0x100000–0x100008.
  - 12 vertex writes at 0x10000C–0x100038.
  - ol_word = 0x40200000.
  - A second strip gets offset 15: ol_word[20:0] = 0x00F.
- Textured, uv16, offset, 4 vertices from reset base 0: vert_words = 6, ol_word = 0x60600000, 27 writes.
- Non-textured, 9 vertices, no eos until the 9th:
  - ol_word = 0x7E200000, overflow = 1.
  - Exactly 35 writes; 9th vertex dropped; IDLE after the eos word.
- vram_wait held high 3 cycles mid-vertex: vram_wr/addr/dout stable, ta_ready low, no lost or duplicated word.
- Strip of 2 vertices with eos: ol_word[30:25] = 0, entry emitted.
- frame_start during VERT, then ol_ready low during EMIT:
  - Aborts with no ol_valid; the next header is written at param_base.
  - ol_word then holds until ol_ready.
